// File: rtl/rx_pattern_checker_pkg.sv
// Shared types, default parameters and seed helper for the receive pattern checker.
package rx_pattern_pkg;

  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_LANE_W    = 32;
  localparam int unsigned DEF_SEED_BASE = 1;
  localparam int unsigned DEF_STEP      = 2;
  localparam int unsigned DEF_LOCK_CNT  = 4;
  localparam int unsigned DEF_CNT_W     = 32;

  // Upper bound on beat width the seed helper can build.
  localparam int unsigned SEED_MAX_W = 1024;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Lane i of the returned vector holds base + i, truncated to lane_w bits.
  function automatic logic [SEED_MAX_W-1:0] seed_vec(input int unsigned data_w,
                                                     input int unsigned lane_w,
                                                     input int unsigned base);
    logic [SEED_MAX_W-1:0] v;
    logic [SEED_MAX_W-1:0] lane_mask;
    v         = '0;
    lane_mask = (SEED_MAX_W'(1) << lane_w) - SEED_MAX_W'(1);
    for (int unsigned i = 0; i < data_w / lane_w; i++) begin
      v = v | ((SEED_MAX_W'(base + i) & lane_mask) << (i * lane_w));
    end
    return v;
  endfunction

endpackage

// File: rtl/rx_pattern_checker_if.sv
// Receive beat bundle between the user-clock datapath and the pattern checker.
interface rx_pattern_checker_if
  import rx_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] usr_rx;
  logic              usr_rx_valid;

  modport master (output usr_rx, output usr_rx_valid);
  modport slave  (input  usr_rx, input  usr_rx_valid);

endinterface

// File: rtl/rx_pattern_checker_lane_cmp.sv
// One counter lane: mismatch flag and next expected value (strict or follow).
module pattern_lane_cmp
  import rx_pattern_pkg::*;
#(
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned STEP   = DEF_STEP
) (
  input  logic [LANE_W-1:0] rx_lane,
  input  logic [LANE_W-1:0] check_lane,
  input  logic              mode_follow,
  output logic              mism,
  output logic [LANE_W-1:0] next_lane
);

  localparam logic [LANE_W-1:0] STEP_L = LANE_W'(STEP);

  logic [LANE_W-1:0] base_lane;

  always_comb begin
    mism      = (rx_lane != check_lane);
    base_lane = mode_follow ? rx_lane : check_lane;
    // Sum is LANE_W wide, so a carry out of this lane is dropped here.
    next_lane = base_lane + STEP_L;
  end

endmodule

// File: rtl/rx_pattern_checker.sv
// Receive test-pattern checker: per-lane compare, lock tracking and saturating statistics.
module rx_pattern_checker
  import rx_pattern_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LANE_W    = DEF_LANE_W,
  parameter int unsigned SEED_BASE = DEF_SEED_BASE,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                       clk_usr,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       mode_follow,
  rx_pattern_checker_if.slave        rx,
  output logic                       err,
  output logic [DATA_W/LANE_W-1:0]   err_lane,
  output logic                       err_sticky,
  output logic                       locked,
  output logic [DATA_W-1:0]          check,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           lock_loss_cnt
);

  localparam int unsigned NUM_LANES = DATA_W / LANE_W;
  localparam int unsigned GR_W      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(LOCK_CNT - 1);

  localparam logic [SEED_MAX_W-1:0] SEED_FULL = seed_vec(DATA_W, LANE_W, SEED_BASE);
  localparam logic [DATA_W-1:0]     SEED      = SEED_FULL[DATA_W-1:0];

  logic [NUM_LANES-1:0] mism;
  logic [DATA_W-1:0]    check_next;
  logic                 beat_bad;
  logic                 clear;

  state_t               state, state_next;
  logic [GR_W-1:0]      good_run, good_run_next;
  logic                 lock_loss_inc;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pattern_lane_cmp #(
      .LANE_W (LANE_W),
      .STEP   (STEP)
    ) u_cmp (
      .rx_lane     (rx.usr_rx[g*LANE_W +: LANE_W]),
      .check_lane  (check[g*LANE_W +: LANE_W]),
      .mode_follow (mode_follow),
      .mism        (mism[g]),
      .next_lane   (check_next[g*LANE_W +: LANE_W])
    );
  end

  assign beat_bad = |mism;
  assign clear    = rst | clr;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk_usr) begin
    if (clear) begin
      state    <= HUNT;
      good_run <= '0;
    end else begin
      state    <= state_next;
      good_run <= good_run_next;
    end
  end

  always_comb begin
    state_next    = state;
    good_run_next = good_run;
    lock_loss_inc = 1'b0;
    if (rx.usr_rx_valid) begin
      case (state)
        HUNT: begin
          if (beat_bad) begin
            good_run_next = '0;
          end else if (good_run == GR_LAST) begin
            state_next    = LOCKED;
            good_run_next = '0;
          end else begin
            good_run_next = good_run + 1'b1;
          end
        end
        LOCKED: begin
          if (beat_bad) begin
            state_next    = HUNT;
            good_run_next = '0;
            lock_loss_inc = 1'b1;
          end
        end
        default: begin
          state_next    = HUNT;
          good_run_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_usr) begin
    if (clear) begin
      err           <= 1'b0;
      err_lane      <= '0;
      err_sticky    <= 1'b0;
      check         <= SEED;
      beat_cnt      <= '0;
      err_cnt       <= '0;
      lock_loss_cnt <= '0;
    end else begin
      err      <= rx.usr_rx_valid & beat_bad;
      err_lane <= rx.usr_rx_valid ? mism : '0;
      if (rx.usr_rx_valid) begin
        check <= check_next;
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (beat_bad) begin
          err_sticky <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
      if (lock_loss_inc && (lock_loss_cnt != '1)) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Directed bench for rx_pattern_checker: vector table plus follow, wrap and saturation sequences.
module tb_rx_pattern_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic        rst_a, clr_a, mode_a;
  logic        err_a, sticky_a, locked_a;
  logic [1:0]  lane_a;
  logic [63:0] check_a;
  logic [31:0] beats_a, errs_a, losses_a;
  rx_pattern_checker_if #(.DATA_W(64)) rx_a ();

  rx_pattern_checker dut_a (
    .clk_usr       (clk),
    .rst           (rst_a),
    .clr           (clr_a),
    .mode_follow   (mode_a),
    .rx            (rx_a),
    .err           (err_a),
    .err_lane      (lane_a),
    .err_sticky    (sticky_a),
    .locked        (locked_a),
    .check         (check_a),
    .beat_cnt      (beats_a),
    .err_cnt       (errs_a),
    .lock_loss_cnt (losses_a)
  );

  // Narrow-counter instance for saturation
  logic        rst_b, clr_b, mode_b;
  logic        err_b, sticky_b, locked_b;
  logic [1:0]  lane_b;
  logic [63:0] check_b;
  logic [3:0]  beats_b, errs_b, losses_b;
  rx_pattern_checker_if #(.DATA_W(64)) rx_b ();

  rx_pattern_checker #(.CNT_W(4)) dut_b (
    .clk_usr       (clk),
    .rst           (rst_b),
    .clr           (clr_b),
    .mode_follow   (mode_b),
    .rx            (rx_b),
    .err           (err_b),
    .err_lane      (lane_b),
    .err_sticky    (sticky_b),
    .locked        (locked_b),
    .check         (check_b),
    .beat_cnt      (beats_b),
    .err_cnt       (errs_b),
    .lock_loss_cnt (losses_b)
  );

  typedef struct {
    logic        rst, clr, mode, valid;
    logic [63:0] rx;
    logic        err;
    logic [1:0]  lane;
    logic        sticky, locked;
    logic [63:0] chk;
    logic [31:0] beats, errs, losses;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] SEED = 64'h0000_0002_0000_0001;

  function automatic vec_t mk(input logic r, input logic c, input logic m, input logic v,
                              input logic [63:0] d, input logic e, input logic [1:0] l,
                              input logic s, input logic lk, input logic [63:0] ck,
                              input logic [31:0] bc, input logic [31:0] ec, input logic [31:0] lc);
    vec_t x;
    x.rst = r; x.clr = c; x.mode = m; x.valid = v; x.rx = d;
    x.err = e; x.lane = l; x.sticky = s; x.locked = lk; x.chk = ck;
    x.beats = bc; x.errs = ec; x.losses = lc;
    return x;
  endfunction

  // k-th beat of the clean strict stream (k = 1 is the seed).
  function automatic logic [63:0] beat(input int k);
    logic [31:0] l1, l0;
    l1 = 32'(2 * k);
    l0 = 32'(2 * k - 1);
    return {l1, l0};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic c, input logic m, input logic v,
                         input logic [63:0] d);
    rst_a = r; clr_a = c; mode_a = m;
    rx_a.usr_rx_valid = v; rx_a.usr_rx = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic v, input logic [63:0] d);
    rst_b = r;
    rx_b.usr_rx_valid = v; rx_b.usr_rx = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic e, input logic [1:0] l, input logic s,
                          input logic lk, input logic [63:0] ck, input logic [31:0] bc,
                          input logic [31:0] ec, input logic [31:0] lc);
    cmp({tag, ".err"},      err_a,    e);
    cmp({tag, ".err_lane"}, lane_a,   l);
    cmp({tag, ".sticky"},   sticky_a, s);
    cmp({tag, ".locked"},   locked_a, lk);
    cmp({tag, ".check"},    check_a,  ck);
    cmp({tag, ".beats"},    beats_a,  bc);
    cmp({tag, ".errs"},     errs_a,   ec);
    cmp({tag, ".losses"},   losses_a, lc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] l1, l0;
    rst_a = 1'b1; clr_a = 1'b0; mode_a = 1'b0;
    rx_a.usr_rx_valid = 1'b0; rx_a.usr_rx = '0;
    rst_b = 1'b1; clr_b = 1'b0; mode_b = 1'b0;
    rx_b.usr_rx_valid = 1'b0; rx_b.usr_rx = '0;

    // Strict clean stream
    tbl.push_back(mk(1, 0, 0, 0, '0, 0, 2'b00, 0, 0, SEED, 0, 0, 0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(0, 0, 0, 1, beat(k), 0, 2'b00, 0, k >= 4, beat(k + 1), k, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, '0, 0, 2'b00, 0, 1, beat(7), 6, 0, 0));
    // Strict with lane 1 of beat 5 corrupted, then clear with a valid beat
    tbl.push_back(mk(1, 0, 0, 0, '0, 0, 2'b00, 0, 0, SEED, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0, 0, 0, 1, beat(k), 0, 2'b00, 0, k >= 4, beat(k + 1), k, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0000000B_00000009, 1, 2'b10, 1, 0, beat(6), 5, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, '0, 0, 2'b00, 1, 0, beat(6), 5, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0000000C_0000000B, 0, 2'b00, 1, 0, beat(7), 6, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, '0, 0, 2'b00, 1, 0, beat(7), 6, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, beat(7), 0, 2'b00, 0, 0, SEED, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, beat(1), 0, 2'b00, 0, 0, beat(2), 1, 0, 0));

    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].clr, tbl[i].mode, tbl[i].valid, tbl[i].rx);
      expect_a($sformatf("vec%0d", i), tbl[i].err, tbl[i].lane, tbl[i].sticky, tbl[i].locked,
               tbl[i].chk, tbl[i].beats, tbl[i].errs, tbl[i].losses);
    end

    // Follow mode from an arbitrary start point
    drive_a(1, 0, 1, 0, '0);
    for (int j = 0; j < 6; j++) begin
      l1 = 32'h12345678 + 32'(2 * j);
      l0 = 32'h9ABCDEF0 + 32'(2 * j);
      drive_a(0, 0, 1, 1, {l1, l0});
      expect_a($sformatf("follow%0d", j), j == 0, (j == 0) ? 2'b11 : 2'b00, 1, j >= 4,
               {l1 + 32'd2, l0 + 32'd2}, 32'(j + 1), 1, 0);
    end

    // Lane wrap without carry between lanes
    drive_a(1, 0, 1, 0, '0);
    for (int j = 0; j < 7; j++) begin
      l1 = 32'hFFFFFFF5 + 32'(2 * j);
      l0 = 32'hFFFFFFF4 + 32'(2 * j);
      drive_a(0, 0, 1, 1, {l1, l0});
      expect_a($sformatf("wrap%0d", j), j == 0, (j == 0) ? 2'b11 : 2'b00, 1, j >= 4,
               {l1 + 32'd2, l0 + 32'd2}, 32'(j + 1), 1, 0);
    end
    cmp("wrap.check_value", check_a, 64'h00000003_00000002);
    drive_a(0, 0, 0, 1, 64'h00000003_00000002);
    expect_a("wrap_strict", 0, 2'b00, 1, 1, 64'h00000005_00000004, 8, 1, 0);

    // Saturation on the 4-bit counter instance
    drive_b(1, 0, '0);
    cmp("sat.reset_errs", errs_b, 4'd0);
    for (int n = 1; n <= 20; n++) begin
      drive_b(0, 1, 64'h0);
      cmp($sformatf("sat%0d.err", n),   err_b,  1'b1);
      cmp($sformatf("sat%0d.lane", n),  lane_b, 2'b11);
      cmp($sformatf("sat%0d.errs", n),  errs_b, (n > 15) ? 4'd15 : 4'(n));
      cmp($sformatf("sat%0d.beats", n), beats_b, (n > 15) ? 4'd15 : 4'(n));
    end
    drive_b(0, 0, 64'h0);
    cmp("sat_idle.err",  err_b,  1'b0);
    cmp("sat_idle.errs", errs_b, 4'd15);
    cmp("sat_idle.sticky", sticky_b, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_pattern_checker.md
Name: rx_pattern_checker

Overview:
- Parametrised receive-side test-pattern checker for the user-clock receive datapath of the fiber card.
- Splits each received beat into NUM_LANES independent counter lanes and compares each lane against its expected value.
- Reports per-beat and per-lane errors, tracks lock, and keeps saturating beat, error and lock-loss statistics for host readout.
- Supports a strict mode (free-running expectation) and a follow mode (expectation resynchronises to received data).

Parameters:
- DATA_W, 64: receive beat width; must be a multiple of LANE_W.
- LANE_W, 32: width of one counter lane; NUM_LANES = DATA_W/LANE_W.
- SEED_BASE, 1: lane i seed = SEED_BASE + i.
- STEP, 2: per-beat increment applied to every lane.
- LOCK_CNT, 4: consecutive good beats needed to declare lock.
- CNT_W, 32: width of all statistics counters.

Ports:
- clk_usr  in  1  user clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous statistics/state clear, same effect as rst.
- mode_follow  in  1  0 = strict, 1 = follow; sampled on every valid beat.
- usr_rx  in  DATA_W  received data beat.
- usr_rx_valid  in  1  beat qualifier.
- err  out  1  one-cycle pulse when the previous valid beat mismatched.
- err_lane  out  NUM_LANES  per-lane mismatch flags, aligned with err.
- err_sticky  out  1  set on the first mismatch; cleared only by rst/clr.
- locked  out  1  lock status.
- check  out  DATA_W  current expected beat.
- beat_cnt  out  CNT_W  valid beats seen.
- err_cnt  out  CNT_W  mismatching beats.
- lock_loss_cnt  out  CNT_W  LOCKED-to-HUNT transitions.

Behaviour:
- Reset and clear
  - rst or clr (both synchronous): err=0, err_lane=0, err_sticky=0, locked=0, all counters=0, state=HUNT, good_run=0.
  - check is loaded with the seed vector; lane i = SEED_BASE+i. Default: 64'h0000_0002_0000_0001.
  - clr (or rst) in the same cycle as usr_rx_valid: clear wins and the beat is discarded, not counted.
- Lane arithmetic
  - All lane arithmetic is modulo 2^LANE_W.
  - Carries never cross lanes, so a lane at 0xFFFF_FFFF with STEP 2 wraps to 0x0000_0001 and its neighbour is unaffected.
- Compare
  - On a valid beat, mism[i] = (usr_rx lane i != check lane i).
  - Next cycle: err = |mism, err_lane = mism.
  - Latency is exactly 1 cycle.
  - On a non-valid cycle, err and err_lane return to 0.
- Next expected value (valid beats only; check holds on non-valid cycles)
  - Strict mode: check lane i <= check lane i + STEP, regardless of errors.
  - Follow mode: check lane i <= usr_rx lane i + STEP.
- State machine: HUNT, LOCKED.
  - HUNT, good beat: good_run++. When good_run reaches LOCK_CNT, go to LOCKED and set locked=1 in the same cycle as that beat's err output.
  - HUNT, bad beat: good_run=0.
  - LOCKED, good beat: stay in LOCKED.
  - LOCKED, bad beat: go to HUNT, locked=0, good_run=0, lock_loss_cnt++.
- Statistics
  - beat_cnt increments on every accepted valid beat.
  - err_cnt increments on every mismatching beat, in any state.
  - All counters saturate at all-ones; they never wrap.
  - err_sticky sets together with the first err pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package rx_pattern_pkg holds:
  - the state enum (HUNT, LOCKED);
  - default parameter constants;
  - a function returning the seed vector for given DATA_W, LANE_W and SEED_BASE.
- Sub-module pattern_lane_cmp holds one lane's compare and next-expected mux (strict/follow). It is generated NUM_LANES times.
- The top level holds the FSM, the good_run counter and the saturating counters.

Test Plan (default parameters unless stated):
- Strict, clean stream: rst, then beats 0x00000002_00000001, 0x00000004_00000003, … for 6 beats -> err stays 0; locked rises on the cycle after the 4th beat; beat_cnt=6; err_cnt=0.
- Strict, corrupt lane 1 of beat 5 (0x0000000B_00000009): err=1 and err_lane=2'b10 one cycle later; locked=0; lock_loss_cnt=1; err_sticky=1. Beat 6, sent correctly as 0x0000000C_0000000B, returns err=0.
- Follow, stream starting at 0x12345678_9ABCDEF0, step 2: first beat gives err=1 (seed mismatch); the following beats give err=0; locked after 4 good beats; err_cnt=1.
- Lane wrap: after lock, beats 0xFFFFFFFF_FFFFFFFE then 0x00000001_00000000 -> no error; check reads 0x00000003_00000002.
- Saturation with CNT_W=4: 20 consecutive bad beats -> err_cnt holds 15; err pulses on every beat.
- clr together with a valid beat mid-stream: beat ignored; all counters 0; locked=0; check=0x00000002_00000001 on the next cycle.
